// File: rtl/clk_tick_gen.sv
// clk_tick_gen: programmable divider producing a square wave, a terminal-count
// tick and a one-shot timer. The divisor and mode are loaded at run time.
// All outputs come straight from flops.
module clk_tick_gen #(
    parameter int unsigned WIDTH        = 28,
    parameter int unsigned DEFAULT_DIV  = 2**27,
    parameter logic [1:0]  DEFAULT_MODE = 2'b00
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] div_in,
    input  logic [1:0]       mode_in,
    input  logic             start,
    output logic             cnt,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        MODE_SQ     = 2'b00,
        MODE_TICK   = 2'b01,
        MODE_ONE    = 2'b10,
        MODE_SQ_ALT = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] div_q, div_d;
    mode_t            mode_q, mode_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             cnt_q, cnt_d;
    logic             tick_q, tick_d;
    state_t           state_q, state_d;

    logic [WIDTH-1:0] term;
    logic             at_term;

    // Terminal value: a zero divisor behaves as a divisor of one.
    always_comb begin
        term    = (div_q == '0) ? '0 : (div_q - WIDTH'(1));
        at_term = (count_q == term);
    end

    // State register with asynchronous reset to the parameterised defaults.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            div_q   <= RST_DIV;
            mode_q  <= mode_t'(DEFAULT_MODE);
            count_q <= '0;
            cnt_q   <= 1'b0;
            tick_q  <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            div_q   <= div_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            state_q <= state_d;
        end
    end

    // Next-state logic: load has priority, then per-mode counting.
    always_comb begin
        div_d   = div_q;
        mode_d  = mode_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        state_d = state_q;

        if (ld) begin
            div_d   = div_in;
            mode_d  = mode_t'(mode_in);
            count_d = '0;
            state_d = ST_IDLE;
            if ((mode_in == MODE_TICK) || (mode_in == MODE_ONE)) begin
                cnt_d = 1'b0;
            end
        end else begin
            unique case (mode_q)
                MODE_ONE: begin
                    cnt_d = 1'b0;
                    unique case (state_q)
                        ST_IDLE: begin
                            count_d = '0;
                            if (start) begin
                                state_d = ST_RUN;
                            end
                        end
                        ST_RUN: begin
                            if (en) begin
                                if (at_term) begin
                                    tick_d  = 1'b1;
                                    count_d = '0;
                                    state_d = ST_IDLE;
                                end else begin
                                    count_d = count_q + WIDTH'(1);
                                end
                            end
                        end
                    endcase
                end
                MODE_TICK: begin
                    cnt_d   = 1'b0;
                    state_d = ST_IDLE;
                    if (en) begin
                        if (at_term) begin
                            tick_d  = 1'b1;
                            count_d = '0;
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                end
                MODE_SQ, MODE_SQ_ALT: begin
                    state_d = ST_IDLE;
                    if (en) begin
                        if (at_term) begin
                            tick_d  = 1'b1;
                            count_d = '0;
                            cnt_d   = ~cnt_q;
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Outputs are direct flop copies.
    always_comb begin
        cnt   = cnt_q;
        tick  = tick_q;
        busy  = (state_q == ST_RUN);
        count = count_q;
    end

endmodule

// File: doc/clk_tick_gen.md
CLK_TICK_GEN -- requirements
Module: clk_tick_gen

Interface
REQ-001 Parameter WIDTH, default 28, divisor and counter width in bits (2..32).
REQ-002 Parameter DEFAULT_DIV, default 2**27, divisor value loaded at reset (must fit in WIDTH bits).
REQ-003 Parameter DEFAULT_MODE, default 2'b00, mode value loaded at reset.
REQ-004 Port clk  in  1  system clock; all state changes on its rising edge.
REQ-005 Port RESET  in  1  asynchronous, active-high reset.
REQ-006 Port en  in  1  count enable; low pauses the counter, with all state held.
REQ-007 Port ld  in  1  synchronous load strobe for div_in and mode_in.
REQ-008 Port div_in  in  WIDTH  new divisor D, captured on ld.
REQ-009 Port mode_in  in  2  new mode, captured on ld: 00 square+tick, 01 tick-only, 10 one-shot, 11 treated as 00.
REQ-010 Port start  in  1  one-shot trigger; ignored outside mode 10.
REQ-011 Port cnt  out  1  registered square wave, period 2*D enabled cycles (modes 00/11).
REQ-012 Port tick  out  1  registered single-cycle pulse at each terminal count.
REQ-013 Port busy  out  1  high while a one-shot is counting.
REQ-014 Port count  out  WIDTH  current counter value.

Function
REQ-015 The block SHALL hold divisor register div and mode register mode, written only by RESET or ld.
REQ-016 The effective divisor SHALL be Deff = 1 when div = 0, else Deff = div; the terminal value is Deff-1 in WIDTH-bit unsigned arithmetic.
REQ-017 In modes 00/01/11, with en=1, count SHALL increment each cycle and wrap to 0 at terminal; with en=0, count, cnt and busy SHALL hold and tick SHALL be 0.
REQ-018 tick SHALL be 1 exactly in the cycle after the edge where en=1 and count=Deff-1, and 0 in all other cycles.
REQ-019 In modes 00/11, cnt SHALL toggle on that same edge; in modes 01/10, cnt SHALL be forced to 0.
REQ-020 In mode 10, state IDLE (busy=0, count=0) SHALL move to RUN (busy=1, count=0) on start=1; start while busy=1 SHALL be ignored.
REQ-021 In RUN with en=1, count SHALL increment; at count=Deff-1, the block SHALL pulse tick for one cycle, clear count, clear busy and return to IDLE.
REQ-022 ld SHALL have priority over en and start in the same cycle: capture div/mode, clear count, tick and busy, leave cnt unchanged except forcing 0 if the new mode is 01/10; start in that cycle is dropped.
REQ-023 ld during RUN SHALL abort the one-shot with no tick.
REQ-024 With Deff=1 in mode 00 and en held high, tick SHALL be 1 every cycle and cnt SHALL toggle every cycle.
REQ-025 There SHALL be no combinational path from any input to any output.

Reset
REQ-026 While RESET=1 (asynchronous, active-high), count=0, tick=0, cnt=0, busy=0, div=DEFAULT_DIV and mode=DEFAULT_MODE regardless of clk.
REQ-027 After RESET deasserts, the first tick SHALL appear after the Deff-th enabled rising edge.
REQ-028 RESET asserted mid-count or mid-one-shot SHALL abort immediately to the reset values, with no tick emitted.

Verification
REQ-029 WIDTH=4, DEFAULT_DIV=3, mode 00, en=1 for 12 cycles -> tick high after edges 3, 6, 9, 12; cnt toggles at each; count sequence is 0,1,2,0,...
REQ-030 ld with div_in=0 and mode_in=00, en=1 -> tick high every cycle and cnt toggles every cycle.
REQ-031 ld with div_in=5 and mode_in=10, start pulse, en=1 -> busy high for 5 cycles, a single tick, then busy=0; a second start during busy has no effect.
REQ-032 Mode 00, div=4, en toggled 1,0,0,1,1,1 -> count holds during en=0; tick appears only after the 4th enabled edge.
REQ-033 ld and start in the same cycle during RUN -> busy=0, count=0, no tick, new div in effect.
REQ-034 RESET asserted asynchronously between edges with count=2 -> count, tick, cnt and busy are 0 before the next edge; div restores to 3.
